// File: rtl/matrix_write_arbiter.sv
// Arbitrates the frame-memory pixel write port between processor writes and a
// screen fill sequencer. Define FILL_CHECKER_EN for a two-colour checkerboard fill.
module matrix_write_arbiter #(
    parameter int MATRIX_WIDTH    = 64,
    parameter int MATRIX_HEIGHT   = 32,
    parameter int ROW_LENGTH      = 7,
    parameter int COLUMN_LENGTH   = 6,
    parameter int INTERFACE_WIDTH = 24,
    parameter int FAIR_LIMIT      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_req,
    input  logic [ROW_LENGTH-1:0]      cpu_row,
    input  logic [COLUMN_LENGTH-1:0]   cpu_col,
    input  logic [INTERFACE_WIDTH-1:0] cpu_data,
    output logic                       cpu_gnt,
    input  logic                       fill_start,
    input  logic                       fill_abort,
    input  logic [INTERFACE_WIDTH-1:0] fill_color,
`ifdef FILL_CHECKER_EN
    input  logic [INTERFACE_WIDTH-1:0] fill_color_alt,
`endif
    output logic                       fill_busy,
    output logic                       fill_done,
    output logic [ROW_LENGTH-1:0]      mem_row,
    output logic [COLUMN_LENGTH-1:0]   mem_col,
    output logic [INTERFACE_WIDTH-1:0] mem_data,
    output logic                       mem_we
);

    localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [FAIR_W-1:0]          r_fair_cnt;
    logic [FAIR_W-1:0]          w_fair_next;
    logic [ROW_LENGTH-1:0]      r_row_cnt;
    logic [ROW_LENGTH-1:0]      w_row_next;
    logic [COLUMN_LENGTH-1:0]   r_col_cnt;
    logic [COLUMN_LENGTH-1:0]   w_col_next;
    logic [INTERFACE_WIDTH-1:0] r_color;
    logic [INTERFACE_WIDTH-1:0] w_fill_pixel;

    logic                       r_mem_we;
    logic [ROW_LENGTH-1:0]      r_mem_row;
    logic [COLUMN_LENGTH-1:0]   r_mem_col;
    logic [INTERFACE_WIDTH-1:0] r_mem_data;
    logic                       r_fill_done;

    logic                       w_cpu_win;
    logic                       w_fill_win;
    logic                       w_last_row;
    logic                       w_last_pixel;

    assign w_last_row   = (r_row_cnt == ROW_LENGTH'(MATRIX_WIDTH - 1));
    assign w_last_pixel = w_last_row && (r_col_cnt == COLUMN_LENGTH'(MATRIX_HEIGHT - 1));

`ifdef FILL_CHECKER_EN
    logic [INTERFACE_WIDTH-1:0] r_color_alt;
    assign w_fill_pixel = (r_row_cnt[0] ^ r_col_cnt[0]) ? r_color_alt : r_color;
`else
    assign w_fill_pixel = r_color;
`endif

    always_comb begin
        w_state_next = r_state;
        w_fair_next  = '0;
        w_row_next   = r_row_cnt;
        w_col_next   = r_col_cnt;
        w_cpu_win    = 1'b0;
        w_fill_win   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cpu_win = cpu_req;
                if (fill_start) begin
                    w_state_next = S_FILL;
                    w_row_next   = '0;
                    w_col_next   = '0;
                end
            end
            S_FILL: begin
                if (fill_abort) begin
                    // The fill gives up its slot; the processor may still use it.
                    w_cpu_win    = cpu_req;
                    w_state_next = S_IDLE;
                    w_row_next   = '0;
                    w_col_next   = '0;
                end else if (cpu_req && (r_fair_cnt != FAIR_W'(FAIR_LIMIT))) begin
                    w_cpu_win   = 1'b1;
                    w_fair_next = r_fair_cnt + FAIR_W'(1);
                end else begin
                    w_fill_win = 1'b1;
                end

                if (w_fill_win) begin
                    if (w_last_pixel) begin
                        w_state_next = S_IDLE;
                        w_row_next   = '0;
                        w_col_next   = '0;
                    end else if (w_last_row) begin
                        w_row_next = '0;
                        w_col_next = r_col_cnt + COLUMN_LENGTH'(1);
                    end else begin
                        w_row_next = r_row_cnt + ROW_LENGTH'(1);
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fair_cnt  <= '0;
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_color     <= '0;
`ifdef FILL_CHECKER_EN
            r_color_alt <= '0;
`endif
            r_mem_we    <= 1'b0;
            r_mem_row   <= '0;
            r_mem_col   <= '0;
            r_mem_data  <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fair_cnt <= w_fair_next;
            r_row_cnt  <= w_row_next;
            r_col_cnt  <= w_col_next;
            if (r_state == S_IDLE && fill_start) begin
                r_color     <= fill_color;
`ifdef FILL_CHECKER_EN
                r_color_alt <= fill_color_alt;
`endif
            end
            r_mem_we    <= w_cpu_win | w_fill_win;
            r_fill_done <= w_fill_win & w_last_pixel;
            // Address and data always come from the same winner.
            if (w_cpu_win) begin
                r_mem_row  <= cpu_row;
                r_mem_col  <= cpu_col;
                r_mem_data <= cpu_data;
            end else if (w_fill_win) begin
                r_mem_row  <= r_row_cnt;
                r_mem_col  <= r_col_cnt;
                r_mem_data <= w_fill_pixel;
            end
        end
    end

    assign cpu_gnt   = w_cpu_win & ~rst;
    assign fill_busy = (r_state == S_FILL);
    assign fill_done = r_fill_done;
    assign mem_we    = r_mem_we;
    assign mem_row   = r_mem_row;
    assign mem_col   = r_mem_col;
    assign mem_data  = r_mem_data;

endmodule

// File: doc/matrix_write_arbiter.md
Name: matrix_write_arbiter

Overview:
- Owns the single pixel write port of the matrix frame memory.
- Shares that port between two requesters:
  - processor write requests from the register interface;
  - a built-in fill sequencer that sweeps every pixel with one colour (screen clear/fill).
- Sits between the register interface and the matrix memory write inputs.
- Refresh-side reads are unaffected.

Parameters:
- MATRIX_WIDTH, 64, pixels per line; range of mem_row.
- MATRIX_HEIGHT, 32, lines; range of mem_col.
- ROW_LENGTH, 7, row address width.
- COLUMN_LENGTH, 6, column address width.
- INTERFACE_WIDTH, 24, pixel word width (R,G,B x 8).
- FAIR_LIMIT, 4, consecutive contested processor grants before the fill engine is forced a slot.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cpu_req  in  1  processor write request; held until granted.
- cpu_row  in  ROW_LENGTH  processor pixel row.
- cpu_col  in  COLUMN_LENGTH  processor pixel column.
- cpu_data  in  INTERFACE_WIDTH  processor pixel word.
- cpu_gnt  out  1  combinational; high in the cycle the processor request wins.
- fill_start  in  1  single-cycle pulse; begins a fill.
- fill_abort  in  1  single-cycle pulse; stops a fill.
- fill_color  in  INTERFACE_WIDTH  fill colour, sampled on accepted fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  single-cycle pulse on completion.
- mem_row  out  ROW_LENGTH  registered write row.
- mem_col  out  COLUMN_LENGTH  registered write column.
- mem_data  out  INTERFACE_WIDTH  registered write data.
- mem_we  out  1  registered write enable.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, counters 0, fair counter 0, latched colour 0.
- FSM states: IDLE, FILL.
  - IDLE -> FILL: on fill_start; latch fill_color; row/col counters cleared to 0.
  - fill_start while in FILL is ignored.
  - FILL -> IDLE: after the last pixel is issued, or on fill_abort.
- Arbitration, evaluated every cycle:
  - Not in FILL: cpu_gnt = cpu_req.
  - FILL without cpu_req: fill engine wins.
  - FILL with cpu_req (contested): processor wins and the fair counter increments.
    - If the fair counter equals FAIR_LIMIT, the fill engine wins instead, cpu_gnt=0, and the counter clears.
  - Counter clears whenever no contest occurs.
- Latency:
  - The winning write appears on mem_* with mem_we=1 exactly one cycle after the decision.
  - mem_we=0 when nobody wins.
  - mem_row/col/data hold their last value when mem_we=0.
- Fill sweep order:
  - Row index increments first, 0..MATRIX_WIDTH-1.
  - On row wrap, column increments, 0..MATRIX_HEIGHT-1.
  - Counters advance only on fill-engine grant.
  - Total of MATRIX_WIDTH*MATRIX_HEIGHT writes (2048 default).
- Completion:
  - fill_done=1 in the same cycle mem_we carries pixel (63,31).
  - fill_busy falls in that same cycle.
  - State is IDLE from that cycle onward.
- fill_busy:
  - Rises the cycle after fill_start is accepted.
  - Stays high while in FILL.
- Abort:
  - fill_abort in FILL overrides the fill grant in that cycle.
  - Next cycle: IDLE, fill_busy=0, no fill_done, counters cleared.
  - Writes already issued remain.
  - fill_abort in IDLE has no effect.
- Simultaneous fill_start and fill_abort in IDLE: start wins.
- Processor and fill data never mix: mem_data always belongs to the same winner as mem_row/mem_col.
- Reset mid-fill: immediate return to IDLE, mem_we=0, no fill_done.

Optional Feature:
- Macro: FILL_CHECKER_EN.
- Defined:
  - Extra input port fill_color_alt (INTERFACE_WIDTH), latched together with fill_color.
  - Pixels where bit0 of (row XOR col) is 1 receive fill_color_alt; all others receive fill_color, giving a checkerboard test pattern.
- Undefined: port absent; every pixel receives fill_color.

Test Plan:
- Reset/idle: assert rst mid-sim -> all outputs 0 asynchronously. Release rst, then cpu_req with row=5, col=3, data=0xFF0000 -> cpu_gnt same cycle; next cycle mem_we=1, mem_row=5, mem_col=3, mem_data=0xFF0000.
- Full fill: fill_start with fill_color=0x00FF00, no cpu_req -> 2048 consecutive mem_we cycles, addresses (0,0),(1,0)...(63,0),(0,1)...(63,31). fill_done pulses once with (63,31); fill_busy low afterward.
- Fairness: cpu_req held high throughout a fill -> the pattern repeats 4 processor grants then 1 fill write. Fill completes after 2048 fill writes; cpu_gnt never high during a forced fill slot.
- Abort: fill_abort after 100 fill writes -> next cycle fill_busy=0, no fill_done, mem_we=0. A new fill_start restarts at (0,0).
- Boundary/ignore cases: fill_start during FILL -> no restart, colour unchanged. fill_abort in IDLE -> no effect. rst during fill -> fill_busy=0 and mem_we=0 immediately.
- FILL_CHECKER_EN: fill_color=0x000000, fill_color_alt=0xFFFFFF -> (0,0)=0x000000, (1,0)=0xFFFFFF, (0,1)=0xFFFFFF, (1,1)=0x000000.
